// File: rtl/load_store_unit.sv
// load_store_unit: one-request-at-a-time RV32I load/store engine between the
// execute stage and a word-addressed, single-cycle-read data memory. Sub-word
// stores are performed as read-modify-write because the bus has no byte
// enables. Every output is a register, so no path exists from req_* to any
// output.
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  output logic [4:0]            resp_rd,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [31:0]           data_address,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  data_csn,
  output logic                  data_wen
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t                  state_reg;
  // A request has been latched in IDLE and is decoded on the following edge.
  logic                    pending_reg;
  logic [31:0]             addr_reg;
  logic [2:0]              funct3_reg;
  logic                    store_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [4:0]              rd_reg;

  logic                    misaligned;
  logic                    illegal;
  logic                    bad_req;
  logic                    is_sw;
  logic [31:0]             word_addr;

  // Extract and extend the addressed byte/halfword of a loaded word.
  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            lane,
    input logic [2:0]            f3
  );
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overlay the store byte/halfword onto the word read back from memory.
  function automatic logic [DATA_WIDTH-1:0] store_merge(
    input logic [DATA_WIDTH-1:0] word,
    input logic [15:0]           wd,
    input logic [1:0]            lane,
    input logic                  byte_op
  );
    logic [DATA_WIDTH-1:0] res;
    res = word;
    if (byte_op) begin
      res[{lane, 3'b000} +: 8] = wd[7:0];
    end else begin
      res[{lane[1], 4'b0000} +: 16] = wd[15:0];
    end
    return res;
  endfunction

  // Classify the latched request: alignment, legality, and the SW fast path.
  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3_reg[1:0])
      2'b01:   misaligned = addr_reg[0];
      2'b10:   misaligned = (addr_reg[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    if (store_reg) begin
      illegal = funct3_reg[2] || (funct3_reg[1:0] == 2'b11);
    end else begin
      illegal = (funct3_reg == 3'b011) || (funct3_reg[2:1] == 2'b11);
    end
    bad_req   = misaligned || illegal;
    is_sw     = store_reg && (funct3_reg == 3'b010);
    word_addr = {2'b00, addr_reg[31:2]};
  end

  // Main FSM: sequences the bus cycles and registers every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pending_reg  <= 1'b0;
      addr_reg     <= '0;
      funct3_reg   <= '0;
      store_reg    <= 1'b0;
      wdata_reg    <= '0;
      rd_reg       <= '0;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rd      <= '0;
      resp_rdata   <= '0;
      data_csn     <= 1'b1;
      data_wen     <= 1'b1;
      data_address <= '0;
      w_data       <= '0;
    end else begin
      resp_valid <= 1'b0;
      data_csn   <= 1'b1;
      data_wen   <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (pending_reg) begin
            pending_reg <= 1'b0;
            if (bad_req) begin
              state_reg  <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rd    <= store_reg ? 5'd0 : rd_reg;
              resp_rdata <= '0;
            end else if (is_sw) begin
              state_reg    <= WRITE;
              data_csn     <= 1'b0;
              data_wen     <= 1'b0;
              data_address <= word_addr;
              w_data       <= wdata_reg;
            end else begin
              state_reg    <= READ;
              data_csn     <= 1'b0;
              data_address <= word_addr;
            end
          end else if (req_ready && req_valid) begin
            pending_reg <= 1'b1;
            req_ready   <= 1'b0;
            addr_reg    <= req_addr;
            funct3_reg  <= req_funct3;
            store_reg   <= req_store;
            wdata_reg   <= req_wdata;
            rd_reg      <= req_rd;
          end else begin
            req_ready <= 1'b1;
          end
        end
        READ: begin
          state_reg <= CAPTURE;
        end
        CAPTURE: begin
          if (store_reg) begin
            state_reg <= WRITE;
            data_csn  <= 1'b0;
            data_wen  <= 1'b0;
            w_data    <= store_merge(r_data, wdata_reg[15:0], addr_reg[1:0],
                                     (funct3_reg[1:0] == 2'b00));
          end else begin
            state_reg  <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rd    <= rd_reg;
            resp_rdata <= load_extract(r_data, addr_reg[1:0], funct3_reg);
          end
        end
        WRITE: begin
          state_reg  <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rd    <= '0;
          resp_rdata <= '0;
        end
        RESP: begin
          state_reg <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit
// against a byte-addressed reference memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] data_address;
  logic [31:0] r_data;
  logic [31:0] w_data;
  logic        data_csn;
  logic        data_wen;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Bus-side memory (16 words) plus backdoor preload port.
  logic [31:0] bus_mem [0:15];
  logic        bd_we;
  logic [3:0]  bd_idx;
  logic [31:0] bd_val;

  // Reference memory, byte addressed.
  logic [7:0]  ref_mem [0:63];

  // Observations of the most recent transaction.
  int          o_lat, o_nrd, o_nwr, o_busk;
  logic [31:0] o_baddr, o_bwdata, o_rdata;
  logic        o_err;
  logic [4:0]  o_rd;

  // Model results.
  logic        m_err;
  logic [31:0] m_rdata;
  int          m_lat, m_nrd, m_nwr;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .data_address(data_address), .r_data(r_data), .w_data(w_data),
    .data_csn(data_csn), .data_wen(data_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: write when wen low, 1-cycle read otherwise.
  always @(posedge clk) begin
    if (bd_we) begin
      bus_mem[bd_idx] <= bd_val;
    end else if (data_csn === 1'b0) begin
      if (data_wen === 1'b0) bus_mem[data_address[3:0]] <= w_data;
      else                   r_data <= bus_mem[data_address[3:0]];
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload_word(input int idx, input logic [31:0] val);
    bd_idx = idx[3:0];
    bd_val = val;
    bd_we  = 1'b1;
    @(negedge clk);
    bd_we  = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[idx * 4 + i] = val[8 * i +: 8];
  endtask

  // Reference model: RV32I access semantics on a little-endian byte array.
  task automatic model_access(input logic st, input logic [2:0] f3, input int a,
                              input logic [31:0] wd);
    int     size;
    bit     legal;
    longint v;
    size  = 1 << f3[1:0];
    legal = st ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    m_err = !legal || (a % size != 0);
    m_rdata = 32'd0;
    if (m_err) begin
      m_lat = 1; m_nrd = 0; m_nwr = 0;
    end else if (!st) begin
      v = 0;
      for (int i = 0; i < size; i++) v = v + (longint'(ref_mem[a + i]) << (8 * i));
      if (f3[2] == 1'b0 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
      m_rdata = v[31:0];
      m_lat = 3; m_nrd = 1; m_nwr = 0;
    end else begin
      for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8 * i +: 8];
      m_lat = (size == 4) ? 2 : 4;
      m_nrd = (size == 4) ? 0 : 1;
      m_nwr = 1;
    end
  endtask

  // Drive one request, then observe the bus and response per cycle after acceptance.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd);
    int guard;
    o_lat = -1; o_nrd = 0; o_nwr = 0; o_busk = -1;
    o_baddr = 0; o_bwdata = 0; o_err = 0; o_rdata = 0; o_rd = 0;
    req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      req_valid = 1'b0;
      return;
    end
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      if (data_csn === 1'b0) begin
        if (o_busk < 0) begin o_busk = k; o_baddr = data_address; end
        if (data_wen === 1'b0) begin o_nwr++; o_bwdata = w_data; end
        else o_nrd++;
      end
      if (resp_valid === 1'b1) begin
        o_lat = k; o_err = resp_err; o_rdata = resp_rdata; o_rd = resp_rd;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total_cnt++; if (data_csn !== 1'b1) $display("FAIL rst_csn got=%b want=1", data_csn); else pass_cnt++;
    total_cnt++; if (data_wen !== 1'b1) $display("FAIL rst_wen got=%b want=1", data_wen); else pass_cnt++;
    total_cnt++; if (data_address !== 32'd0) $display("FAIL rst_addr got=%h want=0", data_address); else pass_cnt++;
    total_cnt++; if (w_data !== 32'd0) $display("FAIL rst_wdata got=%h want=0", w_data); else pass_cnt++;
    total_cnt++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got=%b want=0", resp_valid); else pass_cnt++;
    total_cnt++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err got=%b want=0", resp_err); else pass_cnt++;
    total_cnt++; if (resp_rd !== 5'd0) $display("FAIL rst_resp_rd got=%0d want=0", resp_rd); else pass_cnt++;
    total_cnt++; if (resp_rdata !== 32'd0) $display("FAIL rst_resp_rdata got=%h want=0", resp_rdata); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_ready_in_reset got=%b want=0", req_ready); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_ready_after got=%b want=1", req_ready); else pass_cnt++;
  endtask

  task automatic test_sw();
    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd7);
    model_access(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    $display("txn SW addr=0x10 lat=%0d err=%0d", o_lat, o_err);
    total_cnt++; if (o_busk !== 1) $display("FAIL sw_bus_cycle got=%0d want=1", o_busk); else pass_cnt++;
    total_cnt++; if (o_baddr !== 32'h4) $display("FAIL sw_address got=%h want=4", o_baddr); else pass_cnt++;
    total_cnt++; if (o_nwr !== 1 || o_nrd !== 0) $display("FAIL sw_bus_counts got=%0d/%0d want=0/1", o_nrd, o_nwr); else pass_cnt++;
    total_cnt++; if (o_bwdata !== 32'hDEAD_BEEF) $display("FAIL sw_wdata got=%h want=deadbeef", o_bwdata); else pass_cnt++;
    total_cnt++; if (o_lat !== 2) $display("FAIL sw_latency got=%0d want=2", o_lat); else pass_cnt++;
    total_cnt++; if (o_err !== 1'b0 || o_rd !== 5'd0) $display("FAIL sw_resp got err=%b rd=%0d want 0/0", o_err, o_rd); else pass_cnt++;
  endtask

  task automatic test_loads();
    preload_word(4, 32'h1234_80FF);
    do_req(1'b0, 3'b000, 32'h11, 32'h0, 5'd5);
    $display("txn LB addr=0x11 lat=%0d rdata=0x%08h", o_lat, o_rdata);
    total_cnt++; if (o_rdata !== 32'hFFFF_FF80) $display("FAIL lb_data got=%h want=ffffff80", o_rdata); else pass_cnt++;
    total_cnt++; if (o_lat !== 3) $display("FAIL lb_latency got=%0d want=3", o_lat); else pass_cnt++;
    total_cnt++; if (o_rd !== 5'd5) $display("FAIL lb_rd got=%0d want=5", o_rd); else pass_cnt++;
    total_cnt++; if (o_baddr !== 32'h4 || o_nrd !== 1) $display("FAIL lb_bus got addr=%h reads=%0d want 4/1", o_baddr, o_nrd); else pass_cnt++;
    do_req(1'b0, 3'b100, 32'h11, 32'h0, 5'd6);
    $display("txn LBU addr=0x11 lat=%0d rdata=0x%08h", o_lat, o_rdata);
    total_cnt++; if (o_rdata !== 32'h0000_0080) $display("FAIL lbu_data got=%h want=00000080", o_rdata); else pass_cnt++;
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 5'd0);
    $display("txn LH addr=0x12 lat=%0d rdata=0x%08h", o_lat, o_rdata);
    total_cnt++; if (o_rdata !== 32'h0000_1234) $display("FAIL lh_data got=%h want=00001234", o_rdata); else pass_cnt++;
    total_cnt++; if (o_lat !== 3) $display("FAIL lh_rd0_latency got=%0d want=3", o_lat); else pass_cnt++;
  endtask

  task automatic test_sb_rmw();
    preload_word(4, 32'h1122_3344);
    do_req(1'b1, 3'b000, 32'h13, 32'h0000_00AA, 5'd3);
    model_access(1'b1, 3'b000, 32'h13, 32'h0000_00AA);
    $display("txn SB addr=0x13 lat=%0d wdata=0x%08h", o_lat, o_bwdata);
    total_cnt++; if (o_nrd !== 1 || o_nwr !== 1) $display("FAIL sb_bus_counts got=%0d/%0d want=1/1", o_nrd, o_nwr); else pass_cnt++;
    total_cnt++; if (o_bwdata !== 32'hAA22_3344) $display("FAIL sb_merge got=%h want=aa223344", o_bwdata); else pass_cnt++;
    total_cnt++; if (o_lat !== 4) $display("FAIL sb_latency got=%0d want=4", o_lat); else pass_cnt++;
  endtask

  task automatic test_misaligned_illegal();
    do_req(1'b0, 3'b010, 32'h6, 32'h0, 5'd4);
    $display("txn LW addr=0x6 lat=%0d err=%0d", o_lat, o_err);
    total_cnt++; if (o_err !== 1'b1 || o_lat !== 1) $display("FAIL lw_misaligned got err=%b lat=%0d want 1/1", o_err, o_lat); else pass_cnt++;
    total_cnt++; if (o_nrd + o_nwr !== 0 || o_rdata !== 32'd0) $display("FAIL lw_misaligned_bus got acc=%0d rdata=%h want 0/0", o_nrd + o_nwr, o_rdata); else pass_cnt++;
    do_req(1'b1, 3'b001, 32'h1, 32'h1234, 5'd4);
    $display("txn SH addr=0x1 lat=%0d err=%0d", o_lat, o_err);
    total_cnt++; if (o_err !== 1'b1 || o_lat !== 1) $display("FAIL sh_misaligned got err=%b lat=%0d want 1/1", o_err, o_lat); else pass_cnt++;
    total_cnt++; if (o_nrd + o_nwr !== 0 || o_rdata !== 32'd0) $display("FAIL sh_misaligned_bus got acc=%0d rdata=%h want 0/0", o_nrd + o_nwr, o_rdata); else pass_cnt++;
    do_req(1'b0, 3'b011, 32'h8, 32'h0, 5'd2);
    $display("txn LD-illegal addr=0x8 lat=%0d err=%0d", o_lat, o_err);
    total_cnt++; if (o_err !== 1'b1 || o_lat !== 1 || o_nrd !== 0) $display("FAIL load_illegal got err=%b lat=%0d reads=%0d want 1/1/0", o_err, o_lat, o_nrd); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int          guard, resp_cnt, wr_cnt, first_k;
    logic [31:0] first_rdata, wr_val;
    bit          drop_next, seen_ready;
    preload_word(5, 32'hCAFE_0123);
    req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14; req_wdata = 32'h0; req_rd = 5'd3;
    req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h18; req_wdata = 32'h5A5A_0F0F; req_rd = 5'd9;
    resp_cnt = 0; wr_cnt = 0; first_k = -1; first_rdata = 0; wr_val = 0;
    drop_next = 0; seen_ready = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (drop_next) begin req_valid = 1'b0; drop_next = 0; end
      if (data_csn === 1'b0 && data_wen === 1'b0) begin wr_cnt++; wr_val = w_data; end
      if (resp_valid === 1'b1) begin
        resp_cnt++;
        if (first_k < 0) begin first_k = k; first_rdata = resp_rdata; end
      end
      if (req_ready === 1'b1 && req_valid === 1'b1 && !seen_ready) begin
        seen_ready = 1; drop_next = 1;
      end
    end
    req_valid = 1'b0;
    model_access(1'b0, 3'b010, 32'h14, 32'h0);
    model_access(1'b1, 3'b010, 32'h18, 32'h5A5A_0F0F);
    $display("txn LW+held SW responses=%0d writes=%0d", resp_cnt, wr_cnt);
    total_cnt++; if (first_k !== 3 || first_rdata !== 32'hCAFE_0123) $display("FAIL busy_first_resp got k=%0d data=%h want 3/cafe0123", first_k, first_rdata); else pass_cnt++;
    total_cnt++; if (resp_cnt !== 2) $display("FAIL busy_resp_count got=%0d want=2", resp_cnt); else pass_cnt++;
    total_cnt++; if (wr_cnt !== 1 || wr_val !== 32'h5A5A_0F0F) $display("FAIL busy_single_write got n=%0d data=%h want 1/5a5a0f0f", wr_cnt, wr_val); else pass_cnt++;
  endtask

  task automatic test_reset_inflight();
    int guard, resp_cnt;
    req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h0BAD_F00D; req_rd = 5'd1;
    req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (data_csn !== 1'b0 || data_wen !== 1'b0) $display("FAIL inflight_write_cycle got csn=%b wen=%b want 0/0", data_csn, data_wen); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (data_csn !== 1'b1 || data_wen !== 1'b1) $display("FAIL inflight_rst_bus got csn=%b wen=%b want 1/1", data_csn, data_wen); else pass_cnt++;
    total_cnt++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) $display("FAIL inflight_rst_resp got valid=%b ready=%b want 0/0", resp_valid, req_ready); else pass_cnt++;
    rst = 1'b0;
    resp_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) resp_cnt++;
    end
    // The write cycle was already on the bus when reset was sampled.
    model_access(1'b1, 3'b010, 32'h20, 32'h0BAD_F00D);
    $display("txn SW aborted by reset, late responses=%0d", resp_cnt);
    total_cnt++; if (resp_cnt !== 0) $display("FAIL inflight_no_resp got=%0d want=0", resp_cnt); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL inflight_ready_after got=%b want=1", req_ready); else pass_cnt++;
  endtask

  task automatic test_random();
    logic        st;
    logic [2:0]  f3;
    int          a, sel;
    logic [31:0] wd;
    logic [4:0]  rd;
    for (int n = 0; n < 120; n++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 85) begin
        if (st) f3 = 3'($urandom_range(0, 2));
        else begin
          sel = $urandom_range(0, 4);
          f3 = (sel < 3) ? 3'(sel) : 3'(sel + 1);
        end
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      a  = $urandom_range(0, 63);
      wd = $urandom;
      rd = 5'($urandom_range(0, 31));
      do_req(st, f3, a, wd, rd);
      model_access(st, f3, a, wd);
      $display("txn %0d st=%0d f3=%0d addr=0x%02h lat=%0d err=%0d rdata=0x%08h",
               n, st, f3, a, o_lat, o_err, o_rdata);
      total_cnt++; if (o_lat !== m_lat) $display("FAIL rnd%0d_latency got=%0d want=%0d", n, o_lat, m_lat); else pass_cnt++;
      total_cnt++; if (o_err !== m_err) $display("FAIL rnd%0d_err got=%b want=%b", n, o_err, m_err); else pass_cnt++;
      total_cnt++; if (o_rdata !== m_rdata) $display("FAIL rnd%0d_rdata got=%h want=%h", n, o_rdata, m_rdata); else pass_cnt++;
      total_cnt++; if (o_nrd !== m_nrd || o_nwr !== m_nwr) $display("FAIL rnd%0d_bus got=%0d/%0d want=%0d/%0d", n, o_nrd, o_nwr, m_nrd, m_nwr); else pass_cnt++;
      if (!m_err) begin
        total_cnt++; if (o_baddr !== 32'(a / 4) || o_busk !== 1) $display("FAIL rnd%0d_address got=%h@%0d want=%h@1", n, o_baddr, o_busk, a / 4); else pass_cnt++;
      end
      if (st || !m_err) begin
        total_cnt++; if (o_rd !== (st ? 5'd0 : rd)) $display("FAIL rnd%0d_rd got=%0d want=%0d", n, o_rd, st ? 5'd0 : rd); else pass_cnt++;
      end
    end
  endtask

  task automatic test_memory_image();
    logic [31:0] exp_w;
    for (int w = 0; w < 16; w++) begin
      exp_w = {ref_mem[4 * w + 3], ref_mem[4 * w + 2], ref_mem[4 * w + 1], ref_mem[4 * w]};
      total_cnt++; if (bus_mem[w] !== exp_w) $display("FAIL mem_word%0d got=%h want=%h", w, bus_mem[w], exp_w); else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    bd_we = 1'b0; bd_idx = 4'd0; bd_val = 32'h0;
    repeat (2) @(negedge clk);
    test_reset();
    for (int w = 0; w < 16; w++) preload_word(w, $urandom);
    test_sw();
    test_loads();
    test_sb_rmw();
    test_misaligned_illegal();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    test_memory_image();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
